// File: rtl/router_pkg.sv
// router_pkg: shared state enum, default port count and width helper for the router controller
package router_pkg;
    localparam int DEF_NUM_PORTS = 3;
    typedef enum logic [3:0] {
        DECODE_ADDR,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR,
        WAIT_TILL_EMPTY,
        DROP_PKT
    } router_state_t;
    // ceil(log2(n)) clamped to at least one bit
    function automatic int addr_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/router_ctrl_fsm_if.sv
// router_ctrl_fsm_if: handshake/bus bundle between the byte source, FIFOs, register block and the controller
//   master: drives pkt_valid, din, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid
//   slave : the controller; drives the state decodes, we_en_reg, rst_int_reg, busy, addr_q, addr_err, wait_timeout
interface router_ctrl_fsm_if
    import router_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS,
    parameter int ADDR_W    = addr_width(NUM_PORTS)
);
    logic                 pkt_valid;
    logic [ADDR_W-1:0]    din;
    logic [NUM_PORTS-1:0] fifo_empty;
    logic                 fifo_full;
    logic [NUM_PORTS-1:0] soft_rst;
    logic                 parity_done;
    logic                 low_pkt_valid;
    logic                 detect_add;
    logic                 lfd_state;
    logic                 ld_state;
    logic                 laf_state;
    logic                 full_state;
    logic                 drop_state;
    logic                 we_en_reg;
    logic                 rst_int_reg;
    logic                 busy;
    logic [ADDR_W-1:0]    addr_q;
    logic                 addr_err;
    logic                 wait_timeout;
    modport master (
        output pkt_valid, din, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
               we_en_reg, rst_int_reg, busy, addr_q, addr_err, wait_timeout
    );
    modport slave (
        input  pkt_valid, din, fifo_empty, fifo_full, soft_rst, parity_done, low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, drop_state,
               we_en_reg, rst_int_reg, busy, addr_q, addr_err, wait_timeout
    );
endinterface

// File: rtl/router_wait_timer.sv
// router_wait_timer: cycle counter for the wait-till-empty phase
//   clk, rst : clock, synchronous active-high reset
//   i_clr    : clear the count (has priority over i_en)
//   i_en     : advance the count
//   o_expire : count has reached WAIT_LIMIT-1; held low when WAIT_LIMIT is 0
module router_wait_timer
    import router_pkg::*;
#(
    parameter int WAIT_LIMIT = 64,
    parameter int CW         = addr_width(WAIT_LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    logic [CW-1:0] r_wcnt;
    always_ff @(posedge clk)
        if (rst || i_clr) r_wcnt <= '0;
        else if (i_en) r_wcnt <= r_wcnt + 1'b1;
    assign o_expire = (WAIT_LIMIT != 0) && (r_wcnt == CW'(WAIT_LIMIT - 1));
endmodule

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm: packet-control FSM sequencing header decode, payload, full, parity and drop phases
//   clk, rst : clock, synchronous active-high reset
//   bus      : router_ctrl_fsm_if.slave carrying the source/FIFO/register inputs and the state decodes
module router_ctrl_fsm
    import router_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_W     = addr_width(NUM_PORTS),
    parameter int WAIT_LIMIT = 64
) (
    input logic clk,
    input logic rst,
    router_ctrl_fsm_if.slave bus
);
    // per-port flags padded to the full address range so any address indexes safely
    localparam int EW = 1 << ADDR_W;
    router_state_t     r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_addr_err, r_wait_timeout;
    logic [EW-1:0]     w_empty, w_srst;
    logic              w_bad_addr, w_soft, w_expire, w_in_wte;
    assign w_empty    = EW'(bus.fifo_empty);
    assign w_srst     = EW'(bus.soft_rst);
    assign w_bad_addr = 32'(bus.din) >= NUM_PORTS;
    assign w_soft     = (r_state != DECODE_ADDR) && w_srst[r_addr];
    assign w_in_wte   = r_state == WAIT_TILL_EMPTY;
    always_comb begin
        w_next = r_state;
        if (w_soft) w_next = DECODE_ADDR;
        else
            case (r_state)
                DECODE_ADDR:        if (bus.pkt_valid) w_next = w_bad_addr ? DROP_PKT : w_empty[bus.din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                LOAD_FIRST_DATA:    w_next = LOAD_DATA;
                LOAD_DATA:          w_next = bus.fifo_full ? FIFO_FULL_STATE : !bus.pkt_valid ? LOAD_PARITY : LOAD_DATA;
                FIFO_FULL_STATE:    if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
                LOAD_AFTER_FULL:    w_next = bus.parity_done ? DECODE_ADDR : bus.low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
                LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDR;
                WAIT_TILL_EMPTY:    w_next = w_empty[r_addr] ? LOAD_FIRST_DATA : w_expire ? DROP_PKT : WAIT_TILL_EMPTY;
                DROP_PKT:           if (!bus.pkt_valid) w_next = DECODE_ADDR;
                default:            w_next = DECODE_ADDR;
            endcase
    end
    // error pulses are registered on the transition so they coincide with the first DROP_PKT cycle
    always_ff @(posedge clk)
        if (rst) begin
            r_state        <= DECODE_ADDR;
            r_addr         <= '0;
            r_addr_err     <= 1'b0;
            r_wait_timeout <= 1'b0;
        end else begin
            r_state        <= w_next;
            if (r_state == DECODE_ADDR && bus.pkt_valid) r_addr <= bus.din;
            r_addr_err     <= (r_state == DECODE_ADDR) && (w_next == DROP_PKT);
            r_wait_timeout <= w_in_wte && (w_next == DROP_PKT);
        end
    // counter clears outside WTE and on any exit, so each visit starts from zero
    router_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (!w_in_wte || w_next != WAIT_TILL_EMPTY),
        .i_en     (w_in_wte),
        .o_expire (w_expire)
    );
    assign bus.detect_add   = r_state == DECODE_ADDR;
    assign bus.lfd_state    = r_state == LOAD_FIRST_DATA;
    assign bus.ld_state     = r_state == LOAD_DATA;
    assign bus.laf_state    = r_state == LOAD_AFTER_FULL;
    assign bus.full_state   = r_state == FIFO_FULL_STATE;
    assign bus.drop_state   = r_state == DROP_PKT;
    assign bus.we_en_reg    = r_state inside {LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY};
    assign bus.busy         = r_state inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                              LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY};
    assign bus.rst_int_reg  = r_state == CHECK_PARITY_ERROR;
    assign bus.addr_q       = r_addr;
    assign bus.addr_err     = r_addr_err;
    assign bus.wait_timeout = r_wait_timeout;
endmodule

// File: tb/tb_router_ctrl_fsm.sv
// tb_router_ctrl_fsm: directed bench for router_ctrl_fsm with NUM_PORTS=3, WAIT_LIMIT=4
module tb_router_ctrl_fsm;
    // {detect_add, lfd, ld, laf, full, drop, we_en_reg, busy, rst_int_reg}
    localparam logic [8:0] ST_DA   = 9'b100000_000;
    localparam logic [8:0] ST_LFD  = 9'b010000_010;
    localparam logic [8:0] ST_LD   = 9'b001000_100;
    localparam logic [8:0] ST_LAF  = 9'b000100_110;
    localparam logic [8:0] ST_FFS  = 9'b000010_010;
    localparam logic [8:0] ST_LP   = 9'b000000_110;
    localparam logic [8:0] ST_CPE  = 9'b000000_011;
    localparam logic [8:0] ST_WTE  = 9'b000000_010;
    localparam logic [8:0] ST_DROP = 9'b000001_000;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   we_cnt = 0;

    always #5 clk = ~clk;

    router_ctrl_fsm_if #(.NUM_PORTS(3), .ADDR_W(2)) bus ();
    router_ctrl_fsm #(.NUM_PORTS(3), .ADDR_W(2), .WAIT_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [8:0] exp, input string tag);
        @(posedge clk);
        #1;
        if (bus.we_en_reg) we_cnt++;
        chk(tag, {23'b0, bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                  bus.drop_state, bus.we_en_reg, bus.busy, bus.rst_int_reg}, {23'b0, exp});
    endtask

    initial begin
        rst = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.din = 2'd0;
        bus.fifo_empty = 3'b111;
        bus.fifo_full = 1'b0;
        bus.soft_rst = 3'b000;
        bus.parity_done = 1'b0;
        bus.low_pkt_valid = 1'b0;
        @(posedge clk);
        step(ST_DA, "reset_state");
        chk("reset_addr_q", 32'(bus.addr_q), 0);
        chk("reset_addr_err", 32'(bus.addr_err), 0);
        chk("reset_wait_timeout", 32'(bus.wait_timeout), 0);
        rst = 1'b0;
        step(ST_DA, "idle_stay");

        // normal packet to port 2
        bus.fifo_empty = 3'b100;
        bus.pkt_valid = 1'b1;
        bus.din = 2'd2;
        we_cnt = 0;
        step(ST_LFD, "t1_lfd");
        chk("t1_addr_q", 32'(bus.addr_q), 2);
        bus.din = 2'd0;
        for (int i = 0; i < 4; i++) step(ST_LD, "t1_ld");
        bus.pkt_valid = 1'b0;
        step(ST_LP, "t1_lp");
        step(ST_CPE, "t1_cpe");
        step(ST_DA, "t1_decode");
        chk("t1_we_cycles", we_cnt, 5);
        chk("t1_addr_q_hold", 32'(bus.addr_q), 2);

        // invalid address: drop path
        bus.pkt_valid = 1'b1;
        bus.din = 2'd3;
        step(ST_DROP, "t2_drop1");
        chk("t2_addr_err_pulse", 32'(bus.addr_err), 1);
        step(ST_DROP, "t2_drop2");
        chk("t2_addr_err_once", 32'(bus.addr_err), 0);
        for (int i = 0; i < 4; i++) step(ST_DROP, "t2_drop_n");
        bus.pkt_valid = 1'b0;
        step(ST_DA, "t2_decode");

        // wait-till-empty timeout
        bus.fifo_empty = 3'b000;
        bus.pkt_valid = 1'b1;
        bus.din = 2'd1;
        for (int i = 0; i < 4; i++) step(ST_WTE, "t3_wte");
        chk("t3_no_early_timeout", 32'(bus.wait_timeout), 0);
        step(ST_DROP, "t3_drop");
        chk("t3_timeout_pulse", 32'(bus.wait_timeout), 1);
        chk("t3_no_addr_err", 32'(bus.addr_err), 0);
        step(ST_DROP, "t3_drop2");
        chk("t3_timeout_once", 32'(bus.wait_timeout), 0);
        bus.pkt_valid = 1'b0;
        step(ST_DA, "t3_decode");

        // empty rises in the timeout cycle: LFD wins
        bus.pkt_valid = 1'b1;
        for (int i = 0; i < 4; i++) step(ST_WTE, "t3b_wte");
        bus.fifo_empty = 3'b010;
        step(ST_LFD, "t3b_lfd");
        chk("t3b_no_timeout", 32'(bus.wait_timeout), 0);
        step(ST_LD, "t3b_ld");
        bus.pkt_valid = 1'b0;
        step(ST_LP, "t3b_lp");
        step(ST_CPE, "t3b_cpe");
        step(ST_DA, "t3b_decode");

        // fifo_full during payload, resume through LAF
        bus.fifo_empty = 3'b111;
        bus.pkt_valid = 1'b1;
        bus.din = 2'd0;
        step(ST_LFD, "t4_lfd");
        step(ST_LD, "t4_ld1");
        step(ST_LD, "t4_ld2");
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step(ST_FFS, "t4_ffs");
        bus.fifo_full = 1'b0;
        step(ST_LAF, "t4_laf");
        step(ST_LD, "t4_ld_resume");
        bus.pkt_valid = 1'b0;
        step(ST_LP, "t4_lp");
        step(ST_CPE, "t4_cpe");
        step(ST_DA, "t4_decode");

        // same, parity_done in LAF returns to decode
        bus.pkt_valid = 1'b1;
        step(ST_LFD, "t4b_lfd");
        step(ST_LD, "t4b_ld1");
        step(ST_LD, "t4b_ld2");
        bus.fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) step(ST_FFS, "t4b_ffs");
        bus.fifo_full = 1'b0;
        step(ST_LAF, "t4b_laf");
        bus.pkt_valid = 1'b0;
        bus.parity_done = 1'b1;
        step(ST_DA, "t4b_parity_done");
        bus.parity_done = 1'b0;
        step(ST_DA, "t4b_idle");

        // soft reset: other port ignored, own port (with fifo_full) wins
        bus.pkt_valid = 1'b1;
        bus.din = 2'd2;
        step(ST_LFD, "t5_lfd");
        step(ST_LD, "t5_ld1");
        bus.soft_rst = 3'b001;
        step(ST_LD, "t5_other_port_ignored");
        bus.soft_rst = 3'b100;
        bus.fifo_full = 1'b1;
        step(ST_DA, "t5_soft_rst_own");
        bus.soft_rst = 3'b000;
        bus.fifo_full = 1'b0;
        bus.din = 2'd0;
        bus.soft_rst = 3'b111;
        step(ST_LFD, "t5_soft_ignored_in_decode");
        chk("t5_addr_q", 32'(bus.addr_q), 0);
        bus.soft_rst = 3'b000;
        bus.pkt_valid = 1'b0;
        step(ST_LD, "t5_ld");
        step(ST_LP, "t5_lp");
        step(ST_CPE, "t5_cpe");
        step(ST_DA, "t5_decode");

        // hard reset mid-payload
        bus.pkt_valid = 1'b1;
        bus.din = 2'd2;
        step(ST_LFD, "t6_lfd");
        step(ST_LD, "t6_ld");
        chk("t6_addr_q_before", 32'(bus.addr_q), 2);
        rst = 1'b1;
        step(ST_DA, "t6_reset_state");
        chk("t6_reset_addr_q", 32'(bus.addr_q), 0);
        chk("t6_reset_addr_err", 32'(bus.addr_err), 0);
        chk("t6_reset_timeout", 32'(bus.wait_timeout), 0);
        rst = 1'b0;
        bus.pkt_valid = 1'b0;
        step(ST_DA, "t6_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/router_ctrl_fsm.md
# router_ctrl_fsm

Parametrised packet-control state machine for the N-port router. It sits between the input byte stream and the synchroniser/register blocks. It decodes the header address and sequences first-data, payload, FIFO-full and parity phases for one of `NUM_PORTS` destination FIFOs. Compared with the fixed 1x3 controller, it adds:
- a generic port count;
- a registered destination address used consistently in every state;
- an invalid-address drop path;
- a bounded wait-for-empty timeout with error pulses.

## Interface

Parameters:
- `NUM_PORTS`, 3, number of destination FIFOs (2..16)
- `ADDR_W`, `$clog2(NUM_PORTS)` (min 1), width of header address field
- `WAIT_LIMIT`, 64, maximum cycles in WAIT_TILL_EMPTY before the packet is dropped; 0 disables the timeout

Ports (clock and reset first):
- `clk` in 1 — single clock; all state changes on its rising edge
- `rst` in 1 — synchronous, active-high reset
- `pkt_valid` in 1 — source byte stream valid
- `din` in ADDR_W — header address bits (din[ADDR_W-1:0] of the header byte)
- `fifo_empty` in NUM_PORTS — per-destination FIFO empty flags
- `fifo_full` in 1 — full flag of the currently selected FIFO
- `soft_rst` in NUM_PORTS — per-destination soft reset from the synchroniser
- `parity_done` in 1 — register block has captured the parity byte
- `low_pkt_valid` in 1 — register block saw `pkt_valid` fall
- `detect_add`, `lfd_state`, `ld_state`, `laf_state`, `full_state`, `drop_state` out 1 — Moore state decodes
- `we_en_reg` out 1 — FIFO write enable to the register block
- `rst_int_reg` out 1 — clears the internal parity registers
- `busy` out 1 — back-pressure to the source
- `addr_q` out ADDR_W — latched destination address
- `addr_err` out 1 — one-cycle pulse: header address ≥ NUM_PORTS
- `wait_timeout` out 1 — one-cycle pulse: WAIT_TILL_EMPTY exceeded WAIT_LIMIT

## Operation

- States: DECODE_ADDR, LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), WAIT_TILL_EMPTY (WTE), DROP_PKT.
- `addr_q` loads `din` only in DECODE_ADDR with `pkt_valid`=1. All later decisions use `addr_q`, never live `din`.

Transitions:
- DECODE_ADDR, `pkt_valid`=1:
  - `din` ≥ NUM_PORTS → DROP_PKT, pulse `addr_err`.
  - `fifo_empty[din]`=1 → LFD.
  - otherwise → WTE.
- DECODE_ADDR, `pkt_valid`=0 → stay.
- LFD → LD.
- LD:
  - `fifo_full` → FFS.
  - else `!pkt_valid` → LP.
  - else stay.
- FFS: `!fifo_full` → LAF; else stay.
- LAF:
  - `parity_done` → DECODE_ADDR.
  - else `low_pkt_valid` → LP.
  - else → LD.
- LP → CPE.
- CPE: `fifo_full` → FFS; else → DECODE_ADDR.
- WTE (cycle counter `wcnt` runs only here):
  - `fifo_empty[addr_q]` → LFD.
  - else `WAIT_LIMIT`≠0 and `wcnt`==WAIT_LIMIT-1 → DROP_PKT, pulse `wait_timeout`.
  - else stay and increment `wcnt`.
- DROP_PKT: `!pkt_valid` → DECODE_ADDR; else stay, discarding bytes.

Global rules:
- Priority: `rst` > soft reset > normal transition.
- Soft reset: `soft_rst[addr_q]`=1 in any state except DECODE_ADDR forces DECODE_ADDR. `soft_rst` of other ports is ignored. It is ignored in DECODE_ADDR, where no destination is owned.
- Output decodes:
  - `we_en_reg` = LD | LAF | LP.
  - `busy` = LFD | FFS | LAF | LP | CPE | WTE.
  - `busy`=0 in DROP_PKT, so the source drains.
  - `rst_int_reg` = CPE.
  - `drop_state` = DROP_PKT.

## Timing

- Reset values:
  - state = DECODE_ADDR, so `detect_add`=1.
  - All other state decodes, `we_en_reg`, `busy`, `rst_int_reg` = 0.
  - `addr_q`=0, `wcnt`=0, `addr_err`=0, `wait_timeout`=0.
- Reset mid-packet: next cycle DECODE_ADDR. No write or pulse is issued in that cycle.
- Header in DECODE_ADDR with an empty target: LFD asserted the next cycle and LD the cycle after (2-cycle header-to-payload latency).
- All state-decode outputs are combinational from the state register only; there is no input-to-output combinational path.
- `addr_err` and `wait_timeout` are registered. Each is high for exactly the one cycle in which the state register first holds DROP_PKT.
- `wcnt` clears on every entry to WTE and on leaving it.
- Width of `wcnt`: `$clog2(WAIT_LIMIT+1)`.
- With WAIT_LIMIT=N, DROP_PKT is entered exactly N cycles after WTE was entered.
- Simultaneous events:
  - `fifo_empty[addr_q]` rising in the timeout cycle → LFD wins; no `wait_timeout` pulse.
  - `soft_rst[addr_q]` plus `fifo_full` in LD → DECODE_ADDR.

## Structure

- Shared package `router_pkg`:
  - state enum `router_state_t`;
  - default `NUM_PORTS`;
  - an address-width helper that clamps to a minimum of 1.
- One sub-module: `router_wait_timer`. It holds `wcnt` with load-clear/enable inputs and an `expire` output; `WAIT_LIMIT`=0 ties `expire` low.
- Everything else lives in `router_ctrl_fsm`.

## Test plan

- NUM_PORTS=3. Header din=2 with `fifo_empty`=3'b100, 4 payload bytes, then `pkt_valid` drops. Required sequence: DECODE→LFD→LD×4→LP→CPE→DECODE; `we_en_reg` high exactly 5 cycles; `addr_q`=2.
- NUM_PORTS=3, header din=3 with a 6-byte packet. Required: `addr_err` pulses once; DROP_PKT for 6 cycles with `busy`=0 and `we_en_reg`=0; then DECODE.
- WAIT_LIMIT=4, `fifo_empty[1]` held 0, header din=1. Required: WTE for 4 cycles, then DROP_PKT with a single `wait_timeout` pulse. Repeat with `fifo_empty[1]` rising on the 4th WTE cycle: required LFD and no pulse.
- `fifo_full` asserted on the 2nd LD cycle for 3 cycles, then released. Required: FFS×3, then LAF, then LD resumes. Repeat with `parity_done`=1 in LAF: required return to DECODE.
- Mid-payload `soft_rst[addr_q]` pulse: required DECODE_ADDR the next cycle. A `soft_rst` pulse on a different port: required no effect.
- `rst` asserted in LD with `addr_q`=2: the next cycle must show every output at its reset value.
